mc_control_unit: RTL and testbench

- Multi-cycle MIPS main controller. Moore FSM steps each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath strobe, including the 2-bit extension select consumed by the immediate extender (sign, zero or upper).
- Sits between the instruction register (opcode/funct source) and the datapath: extender, ALU, register file, data memory, PC.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/ctrl_decode.sv | 47 ++++
 rtl/mc_control_unit.sv | 148 ++++++++++++++
 tb/tb_mc_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, states,
// ALU operations, extender selects and PC source selects.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_LD  = 3'b100;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  // Value shown on state_o while parked; the state register itself holds S_IF.
  localparam logic [2:0] S_HALT   = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;

  localparam logic [1:0] EXT_UPPER = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_ZERO  = 2'b10;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic is_rtype;
    logic is_itype_alu;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_jal;
    logic is_jr;
    logic is_halt;
  } ctrl_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: one-hot class flags, extender select and
// the ALU operation an ALU-class instruction needs.
module ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output ctrl_class_t cls,
  output logic [1:0]  ext_sel,
  output logic [2:0]  alu_op
);

  always_comb begin
    cls     = '0;
    ext_sel = EXT_SIGN;
    alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin cls.is_rtype = 1'b1; alu_op = ALU_ADD; end
          FN_SUB: begin cls.is_rtype = 1'b1; alu_op = ALU_SUB; end
          FN_AND: begin cls.is_rtype = 1'b1; alu_op = ALU_AND; end
          FN_OR:  begin cls.is_rtype = 1'b1; alu_op = ALU_OR;  end
          FN_SLT: begin cls.is_rtype = 1'b1; alu_op = ALU_SLT; end
          FN_SLL: begin cls.is_rtype = 1'b1; alu_op = ALU_SLL; end
          FN_JR:  cls.is_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin cls.is_itype_alu = 1'b1; alu_op = ALU_ADD; end
      OP_SLTI: begin cls.is_itype_alu = 1'b1; alu_op = ALU_SLT; end
      OP_ANDI: begin cls.is_itype_alu = 1'b1; alu_op = ALU_AND; ext_sel = EXT_ZERO; end
      OP_ORI:  begin cls.is_itype_alu = 1'b1; alu_op = ALU_OR;  ext_sel = EXT_ZERO; end
      // lui relies on rs = $0, so OR with the upper-extended immediate loads it.
      OP_LUI:  begin cls.is_itype_alu = 1'b1; alu_op = ALU_OR;  ext_sel = EXT_UPPER; end
      OP_LW:   cls.is_load = 1'b1;
      OP_SW:   cls.is_store = 1'b1;
      OP_BEQ, OP_BNE: begin cls.is_branch = 1'b1; alu_op = ALU_SUB; end
      OP_J:    cls.is_jump = 1'b1;
      OP_JAL:  cls.is_jal = 1'b1;
      default: cls.is_halt = (opcode == HALT_OP);
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS main controller: Moore FSM walking IF/ID/EXE/MEM/WB and
// driving every datapath strobe from the current state and instruction fields.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111,
  parameter logic [4:0] RA_REG  = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ExtSel1,
  output logic       ExtSel2,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic       RegWre,
  output logic       WrRegDSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] state_o
);

  // RegDst=00 is hard-wired to the link register inside the register file.
  localparam logic [1:0] REGDST_LINK = (RA_REG == 5'd31) ? REGDST_RA : REGDST_RA;

  logic [2:0]  state_reg, state_next;
  logic        halt_reg, halt_next;
  ctrl_class_t cls;
  logic [1:0]  ext_sel, ext_out;
  logic [2:0]  alu_op;
  logic        is_alu, is_nop, br_taken;

  ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .ext_sel (ext_sel),
    .alu_op  (alu_op)
  );

  assign is_alu   = cls.is_rtype | cls.is_itype_alu;
  assign is_nop   = ~|cls;
  assign br_taken = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
  assign state_o  = halt_reg ? S_HALT : state_reg;
  assign ExtSel1  = ext_out[1];
  assign ExtSel2  = ext_out[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IF;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      halt_reg  <= halt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    halt_next  = halt_reg;
    if (!halt_reg) begin
      case (state_reg)
        S_IF: state_next = S_ID;
        S_ID: begin
          state_next = S_IF;
          if (cls.is_halt)                   halt_next  = 1'b1;
          else if (is_alu)                   state_next = S_EXE_AL;
          else if (cls.is_load | cls.is_store) state_next = S_EXE_LS;
          else if (cls.is_branch)            state_next = S_EXE_BR;
        end
        S_EXE_LS: state_next = S_MEM;
        S_MEM:    state_next = cls.is_load ? S_WB_LD : S_IF;
        S_EXE_AL: state_next = S_WB_AL;
        default:  state_next = S_IF;
      endcase
    end
  end

  always_comb begin
    PCWre = 1'b0; IRWre = 1'b0; InsMemRW = 1'b0; ext_out = EXT_UPPER;
    ALUSrcA = 1'b0; ALUSrcB = 1'b0; ALUOp = ALU_ADD; RegDst = REGDST_RA;
    RegWre = 1'b0; WrRegDSrc = 1'b0; mRD = 1'b0; mWR = 1'b0;
    DBDataSrc = 1'b0; PCSrc = PC_NEXT;
    if (!halt_reg) begin
      case (state_reg)
        S_IF: begin
          IRWre    = 1'b1;
          InsMemRW = 1'b1;
        end
        S_ID: begin
          ext_out = ext_sel;
          PCWre   = cls.is_jump | cls.is_jal | cls.is_jr | is_nop;
          if (cls.is_jump | cls.is_jal) PCSrc = PC_JUMP;
          if (cls.is_jr)                PCSrc = PC_REG;
          if (cls.is_jal) begin
            RegWre = 1'b1;
            RegDst = REGDST_LINK;
          end
        end
        S_EXE_AL, S_WB_AL: begin
          ext_out = ext_sel;
          ALUSrcB = cls.is_itype_alu;
          ALUSrcA = cls.is_rtype & (funct == FN_SLL);
          ALUOp   = alu_op;
          if (state_reg == S_WB_AL) begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            RegDst    = cls.is_rtype ? REGDST_RD : REGDST_RT;
            WrRegDSrc = 1'b1;
          end
        end
        S_EXE_LS, S_MEM, S_WB_LD: begin
          // Address operands stay on the ALU until the access completes.
          ext_out = ext_sel;
          ALUSrcB = 1'b1;
          if (state_reg == S_MEM) begin
            mRD   = cls.is_load;
            mWR   = cls.is_store;
            PCWre = cls.is_store;
          end
          if (state_reg == S_WB_LD) begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            RegDst    = REGDST_RT;
            WrRegDSrc = 1'b1;
            DBDataSrc = 1'b1;
          end
        end
        default: begin
          ext_out = ext_sel;
          ALUOp   = ALU_SUB;
          PCWre   = 1'b1;
          PCSrc   = br_taken ? PC_BRANCH : PC_NEXT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: hand-derived vector table, randomized instruction
// stream against a per-instruction step model, and reset/halt corner sequences.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       PCWre, IRWre, InsMemRW, ExtSel1, ExtSel2, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] RegDst;
  logic       RegWre, WrRegDSrc, mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc;
  logic [2:0] state_o;

  mc_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel1(ExtSel1),
    .ExtSel2(ExtSel2), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .mRD(mRD),
    .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, insmem;
    logic [1:0] ext;
    logic       srca, srcb;
    logic [2:0] aluop;
    logic [1:0] regdst;
    logic       regwre, wrsrc, mrd, mwr, dbsrc;
    logic [1:0] pcsrc;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cycles;
    obs_t       fin;
  } vec_t;

  int checks = 0;
  int failures = 0;

  localparam int K_RALU = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BR = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_HALT = 8, K_NOP = 9;

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o; o.pcwre = PCWre; o.irwre = IRWre; o.insmem = InsMemRW;
    o.ext = {ExtSel1, ExtSel2}; o.srca = ALUSrcA; o.srcb = ALUSrcB;
    o.aluop = ALUOp; o.regdst = RegDst; o.regwre = RegWre; o.wrsrc = WrRegDSrc;
    o.mrd = mRD; o.mwr = mWR; o.dbsrc = DBDataSrc; o.pcsrc = PCSrc;
    return o;
  endfunction

  function automatic obs_t mk(input logic [2:0] st, input logic pcwre, input logic [1:0] ext,
                              input logic srca, input logic srcb, input logic [2:0] aluop,
                              input logic [1:0] regdst, input logic regwre, input logic wrsrc,
                              input logic mrd, input logic mwr, input logic dbsrc,
                              input logic [1:0] pcsrc);
    obs_t o;
    o = '0;
    o.st = st; o.pcwre = pcwre; o.ext = ext; o.srca = srca; o.srcb = srcb;
    o.aluop = aluop; o.regdst = regdst; o.regwre = regwre; o.wrsrc = wrsrc;
    o.mrd = mrd; o.mwr = mwr; o.dbsrc = dbsrc; o.pcsrc = pcsrc;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    int k;
    k = K_NOP;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
            fn == 6'h2a || fn == 6'h00) k = K_RALU;
        else if (fn == 6'h08) k = K_JR;
      end
      6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f: k = K_IALU;
      6'h23: k = K_LW;
      6'h2b: k = K_SW;
      6'h04, 6'h05: k = K_BR;
      6'h02: k = K_J;
      6'h03: k = K_JAL;
      6'h3f: k = K_HALT;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  function automatic int len_of(input int kd);
    if (kd == K_RALU || kd == K_IALU || kd == K_SW) return 4;
    if (kd == K_LW) return 5;
    if (kd == K_BR) return 3;
    return 2;
  endfunction

  function automatic logic [2:0] st_of(input int kd, input int k);
    logic [2:0] path_alu [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
    logic [2:0] path_mem [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    if (k < 2) return k[2:0];
    if (kd == K_RALU || kd == K_IALU) return path_alu[k];
    if (kd == K_BR) return 3'd5;
    return path_mem[k];
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h22: return 3'd1;
        6'h24: return 3'd2;
        6'h25: return 3'd3;
        6'h2a: return 3'd4;
        6'h00: return 3'd5;
        default: return 3'd0;
      endcase
    end
    case (op)
      6'h0a: return 3'd4;
      6'h0c: return 3'd2;
      6'h0d, 6'h0f: return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] ext_of(input logic [5:0] op);
    if (op == 6'h0f) return 2'b00;
    if (op == 6'h0c || op == 6'h0d) return 2'b10;
    return 2'b01;
  endfunction

  function automatic obs_t exp_step(input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input int k);
    obs_t e;
    int   kd;
    bit   last;
    e = '0;
    kd = kind_of(op, fn);
    last = (k == len_of(kd) - 1);
    e.st = st_of(kd, k);
    if (k == 0) begin
      e.irwre = 1'b1;
      e.insmem = 1'b1;
      return e;
    end
    e.ext = ext_of(op);
    e.pcwre = last && (kd != K_HALT);
    case (kd)
      K_RALU, K_IALU: begin
        if (k >= 2) begin
          e.srcb = (kd == K_IALU);
          e.srca = (kd == K_RALU) && (fn == 6'h00);
          e.aluop = aluop_of(op, fn);
        end
        if (k == 3) begin
          e.regwre = 1'b1;
          e.regdst = (kd == K_RALU) ? 2'd2 : 2'd1;
          e.wrsrc = 1'b1;
        end
      end
      K_LW, K_SW: begin
        if (k >= 2) e.srcb = 1'b1;
        if (k == 3) begin
          e.mrd = (kd == K_LW);
          e.mwr = (kd == K_SW);
        end
        if (k == 4) begin
          e.regwre = 1'b1; e.regdst = 2'd1; e.dbsrc = 1'b1; e.wrsrc = 1'b1;
        end
      end
      K_BR: if (k == 2) begin
        e.aluop = 3'd1;
        e.pcsrc = ((op == 6'h04) ? z : !z) ? 2'd1 : 2'd0;
      end
      K_J:  e.pcsrc = 2'd2;
      K_JAL: begin e.pcsrc = 2'd2; e.regwre = 1'b1; end
      K_JR: e.pcsrc = 2'd3;
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Assumes DUT sits in IF; walks the whole instruction against the model.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string tag);
    int n;
    n = len_of(kind_of(op, fn));
    opcode = op; funct = fn; zero = z;
    #1;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s op=%h fn=%h z=%0d step%0d", tag, op, fn, z, k),
            sample(), exp_step(op, fn, z, k));
      tick();
    end
    if (kind_of(op, fn) != K_HALT)
      check($sformatf("%s op=%h return_if", tag, op), sample(), exp_step(op, fn, z, 0));
    $display("instr %s op=%h fn=%h z=%0d states=%0d", tag, op, fn, z, n);
  endtask

  vec_t vt[20];
  logic [5:0] op_pool[14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                              6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] fn_pool[7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};

  initial begin
    obs_t cur, fin, halt_obs;
    int   cyc;
    logic [5:0] rop, rfn;

    vt[0]  = '{6'h00, 6'h20, 1'b0, 4, mk(3'd7, 1, 2'b01, 0, 0, 3'd0, 2'd2, 1, 1, 0, 0, 0, 2'd0)};
    vt[1]  = '{6'h00, 6'h22, 1'b1, 4, mk(3'd7, 1, 2'b01, 0, 0, 3'd1, 2'd2, 1, 1, 0, 0, 0, 2'd0)};
    vt[2]  = '{6'h00, 6'h00, 1'b0, 4, mk(3'd7, 1, 2'b01, 1, 0, 3'd5, 2'd2, 1, 1, 0, 0, 0, 2'd0)};
    vt[3]  = '{6'h00, 6'h2a, 1'b0, 4, mk(3'd7, 1, 2'b01, 0, 0, 3'd4, 2'd2, 1, 1, 0, 0, 0, 2'd0)};
    vt[4]  = '{6'h08, 6'h00, 1'b0, 4, mk(3'd7, 1, 2'b01, 0, 1, 3'd0, 2'd1, 1, 1, 0, 0, 0, 2'd0)};
    vt[5]  = '{6'h0d, 6'h11, 1'b0, 4, mk(3'd7, 1, 2'b10, 0, 1, 3'd3, 2'd1, 1, 1, 0, 0, 0, 2'd0)};
    vt[6]  = '{6'h0f, 6'h00, 1'b0, 4, mk(3'd7, 1, 2'b00, 0, 1, 3'd3, 2'd1, 1, 1, 0, 0, 0, 2'd0)};
    vt[7]  = '{6'h0c, 6'h00, 1'b0, 4, mk(3'd7, 1, 2'b10, 0, 1, 3'd2, 2'd1, 1, 1, 0, 0, 0, 2'd0)};
    vt[8]  = '{6'h23, 6'h00, 1'b0, 5, mk(3'd4, 1, 2'b01, 0, 1, 3'd0, 2'd1, 1, 1, 0, 0, 1, 2'd0)};
    vt[9]  = '{6'h2b, 6'h00, 1'b0, 4, mk(3'd3, 1, 2'b01, 0, 1, 3'd0, 2'd0, 0, 0, 0, 1, 0, 2'd0)};
    vt[10] = '{6'h04, 6'h00, 1'b1, 3, mk(3'd5, 1, 2'b01, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 0, 2'd1)};
    vt[11] = '{6'h04, 6'h00, 1'b0, 3, mk(3'd5, 1, 2'b01, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 0, 2'd0)};
    vt[12] = '{6'h05, 6'h00, 1'b0, 3, mk(3'd5, 1, 2'b01, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 0, 2'd1)};
    vt[13] = '{6'h05, 6'h00, 1'b1, 3, mk(3'd5, 1, 2'b01, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 0, 2'd0)};
    vt[14] = '{6'h02, 6'h00, 1'b0, 2, mk(3'd1, 1, 2'b01, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd2)};
    vt[15] = '{6'h03, 6'h00, 1'b0, 2, mk(3'd1, 1, 2'b01, 0, 0, 3'd0, 2'd0, 1, 0, 0, 0, 0, 2'd2)};
    vt[16] = '{6'h00, 6'h08, 1'b0, 2, mk(3'd1, 1, 2'b01, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd3)};
    vt[17] = '{6'h11, 6'h00, 1'b0, 2, mk(3'd1, 1, 2'b01, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0)};
    vt[18] = '{6'h00, 6'h3f, 1'b0, 2, mk(3'd1, 1, 2'b01, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0)};
    vt[19] = '{6'h0a, 6'h00, 1'b1, 4, mk(3'd7, 1, 2'b01, 0, 1, 3'd4, 2'd1, 1, 1, 0, 0, 0, 2'd0)};

    halt_obs = '0;
    halt_obs.st = 3'b111;

    // Reset held across clock edges keeps IF outputs.
    opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    #2;
    check("reset_async", sample(), exp_step(6'h00, 6'h20, 1'b0, 0));
    tick(); tick();
    check("reset_held", sample(), exp_step(6'h00, 6'h20, 1'b0, 0));
    rst_n = 1'b1;
    run_instr(6'h00, 6'h20, 1'b0, "post_reset_add");

    // Table: instruction length and hand-derived final-state outputs.
    foreach (vt[i]) begin
      opcode = vt[i].op; funct = vt[i].fn; zero = vt[i].z;
      #1;
      cyc = 0;
      fin = '0;
      while (cyc < 12) begin
        tick();
        cyc++;
        cur = sample();
        if (cur.st == 3'd0 && cur.irwre) break;
        fin = cur;
      end
      check_int($sformatf("vec%0d cycles", i), cyc, vt[i].cycles);
      check($sformatf("vec%0d final", i), fin, vt[i].fin);
      $display("vector %0d op=%h fn=%h z=%0d cycles=%0d", i, vt[i].op, vt[i].fn, vt[i].z, cyc);
    end

    // Randomized instruction stream against the model.
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 9) == 0) begin
        rop = 6'($urandom);
        if (rop == 6'h3f) rop = 6'h3e;
      end else begin
        rop = op_pool[$urandom_range(0, 13)];
      end
      rfn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
      run_instr(rop, rfn, 1'($urandom), "rand");
    end

    // Reset pulsed in the middle of EXE_AL.
    opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    tick();
    tick();
    cur = mk(3'd6, 0, 2'b01, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    check("midrst exe_al", sample(), cur);
    #2 rst_n = 1'b0;
    #1 check("midrst immediate_if", sample(), exp_step(6'h00, 6'h20, 1'b0, 0));
    tick();
    check("midrst held_no_regwre", sample(), exp_step(6'h00, 6'h20, 1'b0, 0));
    rst_n = 1'b1;
    run_instr(6'h00, 6'h20, 1'b0, "midrst_resume");

    // Halt parks the FSM until reset.
    run_instr(6'h3f, 6'h00, 1'b0, "halt");
    for (int c = 0; c < 20; c++) begin
      check($sformatf("halt cycle%0d", c), sample(), halt_obs);
      tick();
    end
    rst_n = 1'b0;
    #1 check("halt reset_if", sample(), exp_step(6'h00, 6'h20, 1'b0, 0));
    tick();
    rst_n = 1'b1;
    run_instr(6'h2b, 6'h00, 1'b0, "after_halt_sw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
